// File: rtl/wb_master_bridge.sv
// wb_master_bridge
//   Wishbone B4 pipelined single-transfer initiator. It takes one command on a
//   valid/ready port, runs one stall-aware Wishbone cycle, and returns read
//   data and status on a valid/ready response port. Only one transfer can be
//   outstanding at a time.
//
//   Optional feature: define WBM_TIMEOUT_EN to add a watchdog. The watchdog
//   aborts a cycle that is not terminated within TIMEOUT_CYCLES cycles of stb
//   being asserted. Without it, the bridge waits indefinitely and
//   rsp_timeout_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i      clock (rising edge), asynchronous active-low reset
//   cmd_*                   command port: valid/ready, we, byte address,
//                           write data, byte selects
//   rsp_*                   response port: valid/ready, read data,
//                           error flag, timeout flag
//   busy_o                  high whenever a transfer is in progress
//   wb_*_o / wb_*_i         Wishbone initiator interface (classic single
//                           transfers: cti = 3'b000, bte = 2'b00)
module wb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    output logic [2:0]          wb_cti_o,
    output logic [1:0]          wb_bte_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_stall_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic cmd_fire;
    logic in_cycle;
    logic wb_term;
    logic to_hit;
    logic terminate;
    logic rsp_fire;

    assign cmd_fire  = cmd_valid_i && (state_q == IDLE);
    assign in_cycle  = (state_q == REQ) || (state_q == WAIT);
    assign wb_term   = wb_ack_i || wb_err_i;
    assign terminate = in_cycle && (wb_term || to_hit);
    assign rsp_fire  = (state_q == RESP) && rsp_ready_i;

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt_q;
    logic             rsp_to_q;

    // The last waiting cycle is the one where the count is about to reach
    // TIMEOUT_CYCLES. An ack/err arriving in that same cycle takes priority.
    assign to_hit = in_cycle && !wb_term && (to_cnt_q >= TO_LAST);

    // Watchdog counter: cleared when a command is accepted (entry to REQ).
    // It counts every unterminated cycle of the bus cycle and saturates.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            to_cnt_q <= '0;
        end else if (cmd_fire) begin
            to_cnt_q <= '0;
        end else if (in_cycle && !wb_term && (to_cnt_q != TO_MAX)) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    // The timeout flag is captured alongside the other response fields.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            rsp_to_q <= 1'b0;
        end else if (terminate) begin
            rsp_to_q <= to_hit;
        end else if (rsp_fire) begin
            rsp_to_q <= 1'b0;
        end
    end

    assign rsp_timeout_o = rsp_to_q;
`else
    // No watchdog in this build: a transfer waits for its slave indefinitely.
    assign to_hit        = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign rsp_timeout_o = 1'b0;
`endif

    // State register. An asynchronous reset drops cyc/stb immediately,
    // because both are decoded from this register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. stb is dropped as soon as the slave
    // accepts the request (stall low). cyc is held until ack/err, or until
    // the watchdog fires.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) state_d = REQ;
            end
            REQ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (wb_term || to_hit) state_d = RESP;
                else if (!wb_stall_i)  state_d = WAIT;
            end
            WAIT: begin
                wb_cyc_o = 1'b1;
                if (wb_term || to_hit) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are latched on command acceptance and then held stable
    // for the whole bus cycle. Response fields are captured on termination.
    // err overrides ack, and read data is returned only for a clean read.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (cmd_fire) begin
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_dat_o <= cmd_dat_i;
                wb_sel_o <= cmd_sel_i;
            end
            if (terminate) begin
                rsp_err_o <= wb_err_i || to_hit;
                rsp_dat_o <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
            end else if (rsp_fire) begin
                rsp_err_o <= 1'b0;
                rsp_dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge
//   Table of transfers with a cycle-by-cycle slave model. Expected responses
//   are queued when each command is issued and compared at the response
//   handshake. Hand-written sequences cover the reset-during-WAIT case and
//   (with WBM_TIMEOUT_EN) the watchdog abort followed by a late ack.
module tb_wb_master_bridge;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          stall;
        int          ack_dly;
        logic        s_ack;
        logic        s_err;
        logic [31:0] s_rdata;
        int          hold;
        logic        late_ack;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_to;
        int          exp_cyc;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    wb_master_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i),
        .cmd_dat_i(cmd_dat_i),
        .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o(busy_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic boundExpired(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s wait bound expired", name);
    endtask

    // One complete transfer: issue the command, play the slave, hold off
    // the response for v.hold cycles, then complete the handshake and score.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   cyc_n, stb_n, stall_left, ack_left, guard;
        bit   accepted, adr_bad;

        @(negedge wb_clk_i);
        checkOutput("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_sel_i   = v.sel;
        e.dat = v.exp_dat;
        e.err = v.exp_err;
        e.to  = v.exp_to;
        sb.push_back(e);

        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i   = 32'h1111_2222;
        cmd_dat_i   = 32'h3333_4444;
        checkOutput("wb_adr", wb_adr_o, v.adr);
        checkOutput("wb_we", wb_we_o, v.we);
        checkOutput("wb_sel", wb_sel_o, v.sel);
        checkOutput("wb_dat", wb_dat_o, v.dat);
        checkOutput("cti_bte", {wb_cti_o, wb_bte_o}, 0);
        checkOutput("busy_req", busy_o, 1);

        stall_left = v.stall;
        ack_left   = v.ack_dly;
        accepted   = 0;
        adr_bad    = 0;
        cyc_n      = 0;
        stb_n      = 0;
        guard      = 0;
        while (wb_cyc_o === 1'b1 && guard < 60) begin
            guard++;
            cyc_n++;
            if (wb_adr_o !== v.adr) adr_bad = 1;
            wb_ack_i   = 1'b0;
            wb_err_i   = 1'b0;
            wb_stall_i = 1'b0;
            wb_dat_i   = 32'h0BAD_F00D;
            if (wb_stb_o === 1'b1) begin
                stb_n++;
                if (!accepted) begin
                    if (stall_left > 0) begin
                        wb_stall_i = 1'b1;
                        stall_left--;
                    end else begin
                        accepted = 1;
                    end
                end
            end
            if (accepted && (v.s_ack || v.s_err)) begin
                if (ack_left == 0) begin
                    wb_ack_i = v.s_ack;
                    wb_err_i = v.s_err;
                    wb_dat_i = v.s_rdata;
                end else begin
                    ack_left--;
                end
            end
            @(negedge wb_clk_i);
        end
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_stall_i = 1'b0;
        if (guard >= 60) boundExpired("cyc_drop");

        checkOutput("cyc_cycles", cyc_n, v.exp_cyc);
        checkOutput("stb_cycles", stb_n, v.exp_stb);
        checkOutput("adr_stable", adr_bad, 0);
        checkOutput("rsp_valid_at_drop", rsp_valid_o, 1);

        for (int i = 0; i < v.hold; i++) begin
            cmd_valid_i = 1'b1;
            cmd_we_i    = 1'b1;
            cmd_adr_i   = 32'hDEAD_0000;
            wb_ack_i    = (v.late_ack && i == 0);
            checkOutput("cmd_ready_in_resp", cmd_ready_o, 0);
            checkOutput("no_new_cyc", wb_cyc_o, 0);
            checkOutput("rsp_valid_held", rsp_valid_o, 1);
            @(negedge wb_clk_i);
        end
        wb_ack_i = 1'b0;

        guard = 0;
        while (rsp_valid_o !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge wb_clk_i);
        end
        if (guard >= 20) boundExpired("rsp_valid_wait");

        rsp_ready_i = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("rsp_dat", rsp_dat_o, e.dat);
            checkOutput("rsp_err", rsp_err_o, e.err);
            checkOutput("rsp_timeout", rsp_timeout_o, e.to);
        end else begin
            boundExpired("scoreboard_empty");
        end
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        checkOutput("rsp_valid_clear", rsp_valid_o, 0);
        checkOutput("busy_clear", busy_o, 0);

        if (v.late_ack) begin
            for (int i = 0; i < 3; i++) begin
                wb_ack_i = (i == 0);
                @(negedge wb_clk_i);
                checkOutput("no_second_rsp", rsp_valid_o, 0);
                checkOutput("no_cyc_after_late_ack", wb_cyc_o, 0);
            end
            wb_ack_i = 1'b0;
        end
    endtask

    initial begin
        //        we  adr           dat           sel   st ad ack err rdata         hold late exp_dat      err to cyc stb
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hFEED_FACE, 4'hF, 0, 1, 1'b1, 1'b0, 32'h7777_7777, 0, 1'b0,
                    32'h0000_0000, 1'b0, 1'b0, 2, 1};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 3, 1, 1'b1, 1'b0, 32'hFEED_FACE, 0, 1'b0,
                    32'hFEED_FACE, 1'b0, 1'b0, 5, 4};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0,
                    32'h0000_0000, 1'b1, 1'b0, 1, 1};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 5, 1'b0,
                    32'h1234_5678, 1'b0, 1'b0, 1, 1};
        vecs[4] = '{1'b1, 32'h0000_0008, 32'hCAFE_0001, 4'h3, 1, 2, 1'b0, 1'b1, 32'h5555_AAAA, 0, 1'b0,
                    32'h0000_0000, 1'b1, 1'b0, 4, 2};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h1, 0, 3, 1'b1, 1'b0, 32'hA5A5_A5A5, 1, 1'b0,
                    32'hA5A5_A5A5, 1'b0, 1'b0, 4, 1};

        // Reset values while reset is held.
        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_cyc", wb_cyc_o, 0);
        checkOutput("rst_stb", wb_stb_o, 0);
        checkOutput("rst_we", wb_we_o, 0);
        checkOutput("rst_adr", wb_adr_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp_dat", rsp_dat_o, 0);
        checkOutput("rst_rsp_err", {rsp_err_o, rsp_timeout_o}, 0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("cmd_ready_after_rst", cmd_ready_o, 1);
        checkOutput("busy_after_rst", busy_o, 0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

`ifdef WBM_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0, 2, 1'b1,
                   32'h0000_0000, 1'b1, 1'b1, 8, 1};
            applyStimulus(tv);
        end
`endif

        // Reset asserted while the bridge is in WAIT: the transfer is lost.
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h0000_0080;
        cmd_sel_i   = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        wb_stall_i  = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("wait_cyc", wb_cyc_o, 1);
        checkOutput("wait_stb", wb_stb_o, 0);
        #2 wb_rst_i = 1'b0;
        #1;
        checkOutput("async_rst_cyc", wb_cyc_o, 0);
        checkOutput("async_rst_stb", wb_stb_o, 0);
        checkOutput("async_rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("async_rst_busy", busy_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("post_rst_cmd_ready", cmd_ready_o, 1);
        checkOutput("post_rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("post_rst_adr", wb_adr_o, 0);

        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
